rx_video_capture: RTL and testbench

Receive-side capture engine for the HP instrument's video port: it recovers the incoming monochrome raster and writes it into the frame buffer that the VGA transmit path reads out. Asynchronous VIDEO/HSYNC/VSYNC pins are synchronised into the receive sampling clock. Pixels are sampled mid-cell and packed 8 per byte. Each byte is written to the frame-buffer write port as a single-cycle strobe with no backpressure, because the buffer is a dual-port RAM.

---
 rtl/rx_video_capture.sv | 247 ++++++++++++++++++++++++
 tb/tb_rx_video_capture.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_video_capture.sv
// Receive-side video capture: synchronises VIDEO/HSYNC/VSYNC, samples pixels mid-cell,
// packs 8 pixels per byte (first pixel in bit 7) and writes line-major into a frame buffer.
// Optional feature: define RX_CAPTURE_HPERIOD_EN to build the HSYNC period counter
// that drives hperiod_o; otherwise hperiod_o is tied to zero.
// HStart must be at least 2: the porch counter starts at 1 in the cycle after the HSYNC edge.
module rx_video_capture #(
  parameter int unsigned ClkPerPixel = 4,
  parameter int unsigned HStart      = 40,
  parameter int unsigned HPixels     = 512,
  parameter int unsigned VStart      = 16,
  parameter int unsigned VLines      = 384,
  parameter int unsigned AddrW       = 15
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             video_i,
  input  logic             hsync_i,
  input  logic             vsync_i,
  output logic             wr_en_o,
  output logic [AddrW-1:0] wr_addr_o,
  output logic [7:0]       wr_data_o,
  output logic             frame_done_o,
  output logic             line_short_o,
  output logic [15:0]      hperiod_o
);

  localparam int unsigned PhW    = $clog2(ClkPerPixel);
  localparam int unsigned PixW   = $clog2(HPixels + 1);
  localparam int unsigned PorchW = $clog2(HStart + 1);
  localparam int unsigned CapW   = $clog2(VLines + 1);

  localparam logic [PhW-1:0]    PhLast    = PhW'(ClkPerPixel - 1);
  localparam logic [PhW-1:0]    PhSample  = PhW'(ClkPerPixel / 2);
  localparam logic [PixW-1:0]   PixLast   = PixW'(HPixels);
  localparam logic [PorchW-1:0] PorchLast = PorchW'(HStart - 1);
  localparam logic [CapW-1:0]   CapLast   = CapW'(VLines - 1);
  localparam logic [15:0]       VStartL   = 16'(VStart);
  localparam logic [AddrW-1:0]  LineBytes = AddrW'(HPixels / 8);

  typedef enum logic [1:0] {StWaitVsync, StWaitLine, StHPorch, StActive} state_e;

  state_e state_q, state_d;

  logic [2:0] hs_q, vs_q;
  logic [1:0] vid_q;
  logic       hs_edge, vs_edge, hs_ev, vid;

  logic [15:0]       line_cnt_q, line_cnt_d;
  logic [CapW-1:0]   cap_q, cap_d;
  logic [PorchW-1:0] porch_q, porch_d;
  logic [PhW-1:0]    phase_q, phase_d;
  logic [PixW-1:0]   pix_q, pix_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              byte_rdy_q, byte_rdy_d;
  logic [AddrW-1:0]  addr_q, addr_d, base_q, base_d;
  logic              wr_en_q, wr_en_d;
  logic [AddrW-1:0]  wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              done_pend_q, done_pend_d;
  logic              frame_done_q, frame_done_d;
  logic              line_short_q, line_short_d;

  // Two-flop synchronisers plus a third stage for rising-edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hs_q  <= '0;
      vs_q  <= '0;
      vid_q <= '0;
    end else begin
      hs_q  <= {hs_q[1:0], hsync_i};
      vs_q  <= {vs_q[1:0], vsync_i};
      vid_q <= {vid_q[0], video_i};
    end
  end

  assign hs_edge = hs_q[1] & ~hs_q[2];
  assign vs_edge = vs_q[1] & ~vs_q[2];
  assign hs_ev   = hs_edge & ~vs_edge;  // VSYNC wins a tie
  assign vid     = vid_q[1];

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StWaitVsync;
    else         state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    if (vs_edge) begin
      state_d = StWaitLine;
    end else begin
      case (state_q)
        StWaitLine: if (hs_ev && line_cnt_q >= VStartL) state_d = StHPorch;
        StHPorch:   if (!hs_ev && porch_q == PorchLast) state_d = StActive;
        StActive: begin
          if (hs_ev) begin
            state_d = (cap_q == CapLast) ? StWaitVsync : StHPorch;
          end else if (byte_rdy_q && pix_q == PixLast) begin
            state_d = (cap_q == CapLast) ? StWaitVsync : StWaitLine;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Counters, packing and registered-output next values.
  always_comb begin
    line_cnt_d   = line_cnt_q;
    cap_d        = cap_q;
    porch_d      = porch_q;
    phase_d      = phase_q;
    pix_d        = pix_q;
    shreg_d      = shreg_q;
    byte_rdy_d   = 1'b0;
    addr_d       = addr_q;
    base_d       = base_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    done_pend_d  = 1'b0;
    frame_done_d = done_pend_q;
    line_short_d = line_short_q;
    if (vs_edge) begin
      // New frame (or abort): any pending byte is dropped by the byte_rdy_d default.
      line_cnt_d = '0;
      cap_d      = '0;
      addr_d     = '0;
      base_d     = '0;
    end else begin
      case (state_q)
        StWaitLine: begin
          if (hs_ev) begin
            if (line_cnt_q != 16'hFFFF) line_cnt_d = line_cnt_q + 16'd1;
            porch_d = PorchW'(1);
          end
        end
        StHPorch: begin
          if (hs_ev) begin
            porch_d = PorchW'(1);
          end else begin
            porch_d = porch_q + 1'b1;
            if (porch_q == PorchLast) begin
              phase_d = '0;
              pix_d   = '0;
            end
          end
        end
        StActive: begin
          if (hs_ev) begin
            // Short line: drop the partial byte, jump to the next line start.
            line_short_d = 1'b1;
            cap_d        = cap_q + 1'b1;
            base_d       = base_q + LineBytes;
            addr_d       = base_q + LineBytes;
            porch_d      = PorchW'(1);
          end else begin
            phase_d = (phase_q == PhLast) ? '0 : phase_q + 1'b1;
            if (phase_q == PhSample && pix_q != PixLast) begin
              shreg_d    = {shreg_q[6:0], vid};
              pix_d      = pix_q + 1'b1;
              byte_rdy_d = (pix_q[2:0] == 3'd7);
            end
            if (byte_rdy_q) begin
              wr_en_d   = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = shreg_q;
              addr_d    = addr_q + 1'b1;
              if (pix_q == PixLast) begin
                cap_d       = cap_q + 1'b1;
                base_d      = addr_q + 1'b1;
                done_pend_d = (cap_q == CapLast);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_cnt_q   <= '0;
      cap_q        <= '0;
      porch_q      <= '0;
      phase_q      <= '0;
      pix_q        <= '0;
      shreg_q      <= '0;
      byte_rdy_q   <= 1'b0;
      addr_q       <= '0;
      base_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      done_pend_q  <= 1'b0;
      frame_done_q <= 1'b0;
      line_short_q <= 1'b0;
    end else begin
      line_cnt_q   <= line_cnt_d;
      cap_q        <= cap_d;
      porch_q      <= porch_d;
      phase_q      <= phase_d;
      pix_q        <= pix_d;
      shreg_q      <= shreg_d;
      byte_rdy_q   <= byte_rdy_d;
      addr_q       <= addr_d;
      base_q       <= base_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      done_pend_q  <= done_pend_d;
      frame_done_q <= frame_done_d;
      line_short_q <= line_short_d;
    end
  end

  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign frame_done_o = frame_done_q;
  assign line_short_o = line_short_q;

`ifdef RX_CAPTURE_HPERIOD_EN
  logic [15:0] hcnt_q, hperiod_q;

  // HSYNC period measurement: latch on each edge, restart at 1, saturate at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hcnt_q    <= '0;
      hperiod_q <= '0;
    end else if (hs_edge) begin
      hperiod_q <= hcnt_q;
      hcnt_q    <= 16'd1;
    end else if (hcnt_q != 16'hFFFF) begin
      hcnt_q <= hcnt_q + 16'd1;
    end
  end

  assign hperiod_o = hperiod_q;
`else
  assign hperiod_o = 16'h0000;
`endif

endmodule

// File: tb/tb_rx_video_capture.sv
// Directed bench for rx_video_capture with a small raster: 4 clk/pixel, porch 4,
// 16 pixels/line, 1 skipped line, 2 captured lines. Writes and FRAME_DONE pulses are logged
// with their cycle numbers and checked against hand-computed expectations.
module tb_rx_video_capture;

  localparam int unsigned Cpp = 4;
  localparam int unsigned HSt = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       video, hsync, vsync;
  logic       wr_en, frame_done, line_short;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [15:0] hperiod;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int w_addr[$];
  int w_data[$];
  int w_cyc[$];
  int d_cyc[$];

  rx_video_capture #(
    .ClkPerPixel(4),
    .HStart     (4),
    .HPixels    (16),
    .VStart     (1),
    .VLines     (2),
    .AddrW      (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .video_i     (video),
    .hsync_i     (hsync),
    .vsync_i     (vsync),
    .wr_en_o     (wr_en),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data),
    .frame_done_o(frame_done),
    .line_short_o(line_short),
    .hperiod_o   (hperiod)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every write and frame-done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en) begin
      w_addr.push_back(int'(wr_addr));
      w_data.push_back(int'(wr_data));
      w_cyc.push_back(cyc);
    end
    if (frame_done) d_cyc.push_back(cyc);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int qa(input int i);
    return (i < w_addr.size()) ? w_addr[i] : -1;
  endfunction
  function automatic int qd(input int i);
    return (i < w_data.size()) ? w_data[i] : -1;
  endfunction
  function automatic int qc(input int i);
    return (i < w_cyc.size()) ? w_cyc[i] : -1;
  endfunction
  function automatic int qdone(input int i);
    return (i < d_cyc.size()) ? d_cyc[i] : -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One line of pin activity; HSYNC rises in the first cycle, pixel i occupies
  // pin cycles HSt + i*Cpp .. HSt + i*Cpp + Cpp-1.
  task automatic run_line(input logic [15:0] pix, input int ncyc, output int t0);
    t0 = cyc;
    for (int k = 0; k < ncyc; k++) begin
      hsync = (k < 2);
      if (k >= HSt && k < HSt + 16 * Cpp) video = pix[15 - (k - HSt) / Cpp];
      else video = 1'b0;
      tick(1);
    end
    hsync = 1'b0;
    video = 1'b0;
  endtask

  task automatic pulse_vs();
    vsync = 1'b1;
    tick(2);
    vsync = 1'b0;
    tick(3);
  endtask

  initial begin
    int t0, t1, t2, t3, b, bd;
    rst_n = 1'b0;
    video = 1'b0;
    hsync = 1'b0;
    vsync = 1'b0;
    tick(3);

    // Reset state
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_line_short", int'(line_short), 0);
    chk("rst_hperiod", int'(hperiod), 0);
    rst_n = 1'b1;
    tick(3);

    // Full frame: A5,3C on both lines
    b = w_addr.size();
    bd = d_cyc.size();
    pulse_vs();
    run_line(16'h0000, 80, t0);
    run_line(16'hA53C, 80, t1);
    run_line(16'hA53C, 80, t2);
    tick(5);
    chk("full_nwrites", w_addr.size() - b, 4);
    chk("full_a0", qa(b), 0);
    chk("full_d0", qd(b), 'hA5);
    chk("full_a1", qa(b + 1), 1);
    chk("full_d1", qd(b + 1), 'h3C);
    chk("full_a2", qa(b + 2), 2);
    chk("full_d2", qd(b + 2), 'hA5);
    chk("full_a3", qa(b + 3), 3);
    chk("full_d3", qd(b + 3), 'h3C);
    chk("first_write_cyc", qc(b), t1 + 38);
    chk("second_write_cyc", qc(b + 1), t1 + 70);
    chk("line1_write_cyc", qc(b + 2), t2 + 38);
    chk("full_ndone", d_cyc.size() - bd, 1);
    chk("full_done_cyc", qdone(bd), t2 + 71);
    chk("full_line_short", int'(line_short), 0);

    // Short line: HSYNC after 10 pixels
    b = w_addr.size();
    bd = d_cyc.size();
    pulse_vs();
    run_line(16'h0000, 80, t0);
    run_line(16'h5AC0, 44, t1);
    run_line(16'h0FF0, 80, t2);
    tick(5);
    chk("short_nwrites", w_addr.size() - b, 3);
    chk("short_a0", qa(b), 0);
    chk("short_d0", qd(b), 'h5A);
    chk("short_next_a", qa(b + 1), 2);
    chk("short_next_d", qd(b + 1), 'h0F);
    chk("short_next_cyc", qc(b + 1), t2 + 38);
    chk("short_a3", qa(b + 2), 3);
    chk("short_d3", qd(b + 2), 'hF0);
    chk("short_flag", int'(line_short), 1);
    chk("short_ndone", d_cyc.size() - bd, 1);

    // VSYNC abort during line 1, then restart at address 0
    b = w_addr.size();
    bd = d_cyc.size();
    pulse_vs();
    run_line(16'h0000, 80, t0);
    run_line(16'h1111, 80, t1);
    run_line(16'h2222, 50, t2);
    pulse_vs();
    tick(60);
    chk("abort_ndone", d_cyc.size() - bd, 0);
    chk("abort_nwrites", w_addr.size() - b, 3);
    run_line(16'h0000, 80, t0);
    run_line(16'hC381, 80, t3);
    tick(5);
    chk("restart_nwrites", w_addr.size() - b, 5);
    chk("restart_a", qa(b + 3), 0);
    chk("restart_d", qd(b + 3), 'hC3);
    chk("restart_cyc", qc(b + 3), t3 + 38);
    chk("restart_ndone", d_cyc.size() - bd, 0);

    // Simultaneous HSYNC and VSYNC: the HSYNC edge must not be counted
    b = w_addr.size();
    vsync = 1'b1;
    hsync = 1'b1;
    tick(2);
    vsync = 1'b0;
    hsync = 1'b0;
    tick(3);
    run_line(16'hE7E7, 80, t0);
    run_line(16'h1248, 80, t1);
    tick(5);
    chk("tie_nwrites", w_addr.size() - b, 2);
    chk("tie_a0", qa(b), 0);
    chk("tie_d0", qd(b), 'h12);
    chk("tie_d1", qd(b + 1), 'h48);

    // Reset mid-ACTIVE
    pulse_vs();
    run_line(16'h0000, 80, t0);
    run_line(16'hFFFF, 30, t1);
    rst_n = 1'b0;
    #2;
    chk("midrst_wr_en", int'(wr_en), 0);
    chk("midrst_wr_addr", int'(wr_addr), 0);
    chk("midrst_wr_data", int'(wr_data), 0);
    chk("midrst_frame_done", int'(frame_done), 0);
    chk("midrst_line_short", int'(line_short), 0);
    chk("midrst_hperiod", int'(hperiod), 0);
    tick(3);
    rst_n = 1'b1;
    tick(3);
    b = w_addr.size();
    bd = d_cyc.size();
    run_line(16'hFFFF, 80, t0);
    run_line(16'hFFFF, 80, t0);
    tick(5);
    chk("postrst_nwrites", w_addr.size() - b, 0);
    chk("postrst_ndone", d_cyc.size() - bd, 0);
    pulse_vs();
    run_line(16'h0000, 80, t0);
    run_line(16'h9966, 80, t1);
    tick(5);
    chk("postrst_vs_a", qa(b), 0);
    chk("postrst_vs_d", qd(b), 'h99);

    // HSYNC period measurement
    hsync = 1'b1;
    tick(2);
    hsync = 1'b0;
    tick(998);
    hsync = 1'b1;
    tick(2);
    hsync = 1'b0;
    tick(5);
`ifdef RX_CAPTURE_HPERIOD_EN
    chk("hperiod_1000", int'(hperiod), 1000);
    tick(70000 - 7);
    hsync = 1'b1;
    tick(2);
    hsync = 1'b0;
    tick(5);
    chk("hperiod_sat", int'(hperiod), 'hFFFF);
`else
    chk("hperiod_off", int'(hperiod), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
